// File: rtl/instruction_fetch.sv
// instruction_fetch: issues word fetches for the current PC, tags each
// returned word with its PC in an in-order reservation queue and presents
// {instruction, PC} to decode. A flush drops queued entries and arranges for
// the responses of fetches still in flight to be dropped when they return.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to block misaligned PCs and
// raise FetchFault instead of issuing them. Without the macro PcIn is issued
// unchanged and FetchFault is tied low.
module instruction_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PcIn,
  output logic        PcAdvance,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemReqAddr,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  input  logic        Flush,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrData,
  output logic [31:0] InstrPc,
  output logic        FetchFault
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit distinguishes a full queue from an empty one.
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  logic [PW-1:0] alloc_q, alloc_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] read_q, read_d;
  // Responses still owed by memory for fetches abandoned by a flush.
  logic [PW-1:0] discard_q, discard_d;
  logic [31:0]   pc_q [DEPTH];
  logic [31:0]   pc_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [PW-1:0] used;
  logic [PW-1:0] unfilled;
  logic [PW-1:0] in_use;
  logic [PW-1:0] flush_owed;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] read_idx;
  logic          misaligned;
  logic          req_valid;
  logic          accept;
  logic          resp_keep;
  logic          instr_valid;
  logic          pop;

  assign alloc_idx = alloc_q[AW-1:0];
  assign fill_idx  = fill_q[AW-1:0];
  assign read_idx  = read_q[AW-1:0];

  assign used       = alloc_q - read_q;
  assign unfilled   = alloc_q - fill_q;
  // used + discard never exceeds DEPTH because issue stops at DEPTH.
  assign in_use     = used + discard_q;
  assign flush_owed = discard_q + unfilled;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = (PcIn[1:0] != 2'b00);
  assign FetchFault = misaligned && !Flush && !Reset;
`else
  assign misaligned = 1'b0;
  assign FetchFault = 1'b0;
`endif

  // Request valid is independent of ready; Reset gates it while state clears.
  assign req_valid = !Reset && !Flush && !misaligned && (in_use < DEPTH_P);
  assign accept    = req_valid && ImemReqReady;
  assign resp_keep = ImemRespValid && !Flush && (discard_q == '0);

  assign instr_valid = !Flush && (used != '0) && filled_q[read_idx];
  assign pop         = instr_valid && InstrReady;

  assign ImemReqValid = req_valid;
  assign ImemReqAddr  = PcIn;
  assign PcAdvance    = accept;
  assign InstrValid   = instr_valid;
  assign InstrData    = data_q[read_idx];
  assign InstrPc      = pc_q[read_idx];

  // Next-state for pointers, discard counter and queue entries.
  always_comb begin
    alloc_d   = alloc_q;
    fill_d    = fill_q;
    read_d    = read_q;
    discard_d = discard_q;
    pc_d      = pc_q;
    data_d    = data_q;
    filled_d  = filled_q;

    if (Flush) begin
      alloc_d  = '0;
      fill_d   = '0;
      read_d   = '0;
      filled_d = '0;
      // A response arriving in the flush cycle is itself dropped, so it
      // no longer counts toward what is still owed.
      if (ImemRespValid && (flush_owed != '0)) begin
        discard_d = flush_owed - ONE_P;
      end else begin
        discard_d = flush_owed;
      end
    end else begin
      if (accept) begin
        alloc_d             = alloc_q + ONE_P;
        pc_d[alloc_idx]     = PcIn;
        filled_d[alloc_idx] = 1'b0;
      end
      if (resp_keep) begin
        fill_d             = fill_q + ONE_P;
        data_d[fill_idx]   = ImemRespData;
        filled_d[fill_idx] = 1'b1;
      end else if (ImemRespValid) begin
        discard_d = discard_q - ONE_P;
      end
      if (pop) begin
        read_d = read_q + ONE_P;
      end
    end
  end

  // State registers; reset also clears entry contents so outputs read zero.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alloc_q   <= '0;
      fill_q    <= '0;
      read_q    <= '0;
      discard_q <= '0;
      pc_q      <= '{default: '0};
      data_q    <= '{default: '0};
      filled_q  <= '0;
    end else begin
      alloc_q   <= alloc_d;
      fill_q    <= fill_d;
      read_q    <= read_d;
      discard_q <= discard_d;
      pc_q      <= pc_d;
      data_q    <= data_d;
      filled_q  <= filled_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch (DEPTH = 2). A small instruction
// memory model returns {16'hC0DE, addr[15:0]} a fixed number of cycles after
// each accepted request; the bench plays the PC stage, stepping PcIn by 4
// after every PcAdvance. Misaligned-PC expectations follow
// FETCH_ALIGN_CHECK_EN.
module tb_instruction_fetch;

  logic        Clk;
  logic        Reset;
  logic [31:0] PcIn;
  logic        PcAdvance;
  logic        ImemReqValid;
  logic        ImemReqReady;
  logic [31:0] ImemReqAddr;
  logic        ImemRespValid;
  logic [31:0] ImemRespData;
  logic        Flush;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] InstrData;
  logic [31:0] InstrPc;
  logic        FetchFault;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mem_req_t;

  mem_req_t mq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int last_pop_cyc = -1;

  instruction_fetch #(.DEPTH(2)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PcIn         (PcIn),
    .PcAdvance    (PcAdvance),
    .ImemReqValid (ImemReqValid),
    .ImemReqReady (ImemReqReady),
    .ImemReqAddr  (ImemReqAddr),
    .ImemRespValid(ImemRespValid),
    .ImemRespData (ImemRespData),
    .Flush        (Flush),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .InstrData    (InstrData),
    .InstrPc      (InstrPc),
    .FetchFault   (FetchFault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: capture acceptance in the settled cycle, cross the edge, then
  // drive the PC stage and memory response for the new cycle.
  task automatic tick();
    bit acc;
    acc = ImemReqValid && ImemReqReady;
    if (acc) mq.push_back('{due: cyc + mem_lat, addr: ImemReqAddr});
    @(posedge Clk);
    #1;
    cyc++;
    if (acc) PcIn = PcIn + 32'd4;
    if (mq.size() > 0 && mq[0].due == cyc) begin
      ImemRespValid = 1'b1;
      ImemRespData  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      ImemRespValid = 1'b0;
      ImemRespData  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    Reset = 1'b1;
    Flush = 1'b0;
    InstrReady = 1'b0;
    ImemReqReady = 1'b1;
    PcIn = start_pc;
    ImemRespValid = 1'b0;
    ImemRespData = 32'h0;
    mq.delete();
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc = 0;
    #1;
  endtask

  task automatic expect_pop(input string tag, input logic [31:0] exp_pc, input int budget);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      if (InstrValid && InstrReady) begin
        check_val({tag, " pc"}, InstrPc, exp_pc);
        check_val({tag, " data"}, InstrData, word_of(exp_pc));
        last_pop_cyc = cyc;
        got = 1'b1;
      end
      tick();
      n++;
    end
    if (!got) check_val({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    Reset = 1'b1;
    Flush = 1'b0;
    InstrReady = 1'b0;
    ImemReqReady = 1'b1;
    PcIn = 32'h0;
    ImemRespValid = 1'b0;
    ImemRespData = 32'h0;
    #2;

    // Reset state while Reset is held.
    check_val("rst valid", 32'(InstrValid), 32'd0);
    check_val("rst advance", 32'(PcAdvance), 32'd0);
    check_val("rst reqvalid", 32'(ImemReqValid), 32'd0);
    check_val("rst data", InstrData, 32'h0);
    check_val("rst pc", InstrPc, 32'h0);
    check_val("rst fault", 32'(FetchFault), 32'd0);

    // Streaming: 1-cycle memory, decode always ready.
    mem_lat = 1;
    do_reset(32'h0);
    InstrReady = 1'b1;
    #1;
    check_val("stream first accept", 32'(PcAdvance), 32'd1);
    expect_pop("stream 0", 32'h00, 10);
    check_val("stream first cycle", 32'(last_pop_cyc), 32'd2);
    expect_pop("stream 1", 32'h04, 10);
    expect_pop("stream 2", 32'h08, 10);
    expect_pop("stream 3", 32'h0C, 10);

    // Back-pressure: request valid regardless of ready, queue fills at 2.
    do_reset(32'h0);
    ImemReqReady = 1'b0;
    #1;
    check_val("bp valid no ready", 32'(ImemReqValid), 32'd1);
    check_val("bp no advance", 32'(PcAdvance), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin
        ImemReqReady = 1'b1;
        #1;
      end
      if (PcAdvance) cnt++;
      tick();
    end
    check_val("bp advance count", 32'(cnt), 32'd2);
    check_val("bp full reqvalid", 32'(ImemReqValid), 32'd0);
    InstrReady = 1'b1;
    #1;
    expect_pop("bp 0", 32'h00, 4);
    expect_pop("bp 1", 32'h04, 4);

    // Flush with two fetches in flight, memory latency 3.
    mem_lat = 3;
    do_reset(32'h0);
    InstrReady = 1'b1;
    #1;
    tick();
    tick();
    Flush = 1'b1;
    #1;
    check_val("fl2 valid in flush", 32'(InstrValid), 32'd0);
    check_val("fl2 reqvalid in flush", 32'(ImemReqValid), 32'd0);
    tick();
    Flush = 1'b0;
    PcIn = 32'h40;
    #1;
    check_val("fl2 drain holds issue", 32'(PcAdvance), 32'd0);
    expect_pop("fl2 first", 32'h40, 12);

    // Flush in the same cycle as a response, memory latency 2.
    mem_lat = 2;
    do_reset(32'h0);
    InstrReady = 1'b1;
    #1;
    tick();
    tick();
    check_val("fl1 resp present", 32'(ImemRespValid), 32'd1);
    Flush = 1'b1;
    #1;
    check_val("fl1 valid in flush", 32'(InstrValid), 32'd0);
    tick();
    Flush = 1'b0;
    PcIn = 32'h80;
    #1;
    check_val("fl1 issue after", 32'(PcAdvance), 32'd1);
    check_val("fl1 addr", ImemReqAddr, 32'h80);
    tick();
    check_val("fl1 no stale", 32'(InstrValid), 32'd0);
    expect_pop("fl1 first", 32'h80, 8);

    // Flush withdraws a request that would otherwise be accepted.
    mem_lat = 1;
    do_reset(32'h0);
    Flush = 1'b1;
    #1;
    check_val("wd reqvalid", 32'(ImemReqValid), 32'd0);
    check_val("wd advance", 32'(PcAdvance), 32'd0);
    tick();
    Flush = 1'b0;
    #1;
    check_val("wd issue after", 32'(PcAdvance), 32'd1);

    // Reset mid-operation with two entries queued.
    do_reset(32'h0);
    #1;
    tick();
    tick();
    check_val("mid pre valid", 32'(InstrValid), 32'd1);
    Reset = 1'b1;
    mq.delete();
    ImemRespValid = 1'b0;
    ImemRespData = 32'h0;
    #1;
    check_val("mid valid", 32'(InstrValid), 32'd0);
    check_val("mid advance", 32'(PcAdvance), 32'd0);
    check_val("mid data", InstrData, 32'h0);
    check_val("mid pc", InstrPc, 32'h0);
    check_val("mid reqvalid", 32'(ImemReqValid), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    PcIn = 32'h0;
    InstrReady = 1'b1;
    cyc = 0;
    #1;
    expect_pop("mid restart", 32'h00, 6);
    check_val("mid restart cycle", 32'(last_pop_cyc), 32'd2);

    // Misaligned PC.
    do_reset(32'h06);
`ifdef FETCH_ALIGN_CHECK_EN
    check_val("mis fault", 32'(FetchFault), 32'd1);
    check_val("mis reqvalid", 32'(ImemReqValid), 32'd0);
    check_val("mis advance", 32'(PcAdvance), 32'd0);
    Flush = 1'b1;
    #1;
    check_val("mis fault in flush", 32'(FetchFault), 32'd0);
    tick();
    Flush = 1'b0;
    PcIn = 32'h08;
    #1;
    check_val("mis realigned fault", 32'(FetchFault), 32'd0);
    check_val("mis realigned issue", 32'(PcAdvance), 32'd1);
`else
    check_val("mis fault", 32'(FetchFault), 32'd0);
    check_val("mis reqvalid", 32'(ImemReqValid), 32'd1);
    check_val("mis addr", ImemReqAddr, 32'h06);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
